// File: rtl/mips_pkg.sv
// Shared fetch/decode definitions: reset vector, bubble word,
// fetch FSM states, IF/ID bundle and instruction field positions.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] pc_plus4(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {data, pc4} holding register for a word accepted while
// decode stalls. Ports: load/drain/clear controls, data/pc4 in/out, full.
module if_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] data,
  output logic [31:0] pc4,
  output logic        full
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      pc4  <= '0;
      full <= 1'b0;
    end else if (clear || drain) begin
      full <= 1'b0;
    end else if (load) begin
      data <= data_in;
      pc4  <= pc4_in;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, stalled memory read handshake, IF/ID
// register with skid buffer, redirects (incl. while a read is pending).
module inst_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic [31:0] iMemRdata,
  input  logic        iMemStall,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic [31:0] oIR,
  output logic [5:0]  oIR_opcode,
  output logic [5:0]  oIR_func,
  output logic [31:0] oPC4,
  output logic        oValid,
  output logic        oMisalign
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q;
  logic [31:0]  pc4;
  if_id_t       ifid_q;

  logic pc_en;
  logic ld_mem;
  logic ld_skid;
  logic ld_bub;
  logic skid_ld;
  logic skid_drain;
  logic skid_clr;
  logic drain_en;
  logic redir;
  logic accept;

  logic [31:0] skid_data;
  logic [31:0] skid_pc4;
  logic        skid_full;

  assign pc4     = pc_plus4(pc_q);
  assign oMemReq = (state_q == S_FETCH) || (state_q == S_DRAIN);
  // While draining, the abandoned read's address must stay on the bus.
  assign oMemAddr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign accept   = oMemReq && !iMemStall;
  assign redir    = iRedirect && (state_q != S_IDLE);

  assign oMisalign = redir && (iRedirectPC[1:0] != 2'b00);

  assign oIR        = ifid_q.ir;
  assign oPC4       = ifid_q.pc4;
  assign oValid     = ifid_q.valid;
  assign oIR_opcode = ifid_q.ir[OP_HI:OP_LO];
  assign oIR_func   = ifid_q.ir[FN_HI:FN_LO];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_en      = 1'b0;
    ld_mem     = 1'b0;
    ld_skid    = 1'b0;
    ld_bub     = 1'b0;
    skid_ld    = 1'b0;
    skid_drain = 1'b0;
    skid_clr   = 1'b0;
    drain_en   = 1'b0;
    if (redir) begin
      pc_en    = 1'b1;
      pc_d     = {iRedirectPC[31:2], 2'b00};
      ld_bub   = 1'b1;
      skid_clr = 1'b1;
      if (state_q == S_DRAIN) begin
        state_d = S_DRAIN;
      end else if (state_q == S_FETCH && iMemStall) begin
        state_d  = S_DRAIN;
        drain_en = 1'b1;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (accept) begin
            pc_en = 1'b1;
            pc_d  = pc4;
            if (iStall) begin
              skid_ld = 1'b1;
              state_d = S_HOLD;
            end else begin
              ld_mem = 1'b1;
            end
          end else if (!iStall) begin
            ld_bub = 1'b1;
          end
        end
        S_HOLD: begin
          if (!iStall) begin
            ld_skid    = 1'b1;
            skid_drain = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (!iMemStall) state_d = S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      if (pc_en)    pc_q         <= pc_d;
      if (drain_en) drain_addr_q <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= '{ir: NOP_WORD, pc4: 32'd0, valid: 1'b0};
    end else begin
      unique case (1'b1)
        ld_bub:  ifid_q <= '{ir: NOP_WORD, pc4: ifid_q.pc4, valid: 1'b0};
        ld_mem:  ifid_q <= '{ir: iMemRdata, pc4: pc4, valid: 1'b1};
        ld_skid: ifid_q <= '{ir: skid_data, pc4: skid_pc4, valid: skid_full};
        default: ifid_q <= ifid_q;
      endcase
    end
  end

  if_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_ld),
    .drain   (skid_drain),
    .clear   (skid_clr),
    .data_in (iMemRdata),
    .pc4_in  (pc4),
    .data    (skid_data),
    .pc4     (skid_pc4),
    .full    (skid_full)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: zero-wait fetch, memory stall,
// decode stall/skid, drain redirect, misalign, PC wrap, async reset.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ir;
  logic [5:0]  ir_opcode;
  logic [5:0]  ir_func;
  logic [31:0] pc4;
  logic        valid;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .oMemReq     (mem_req),
    .oMemAddr    (mem_addr),
    .iMemRdata   (mem_rdata),
    .iMemStall   (mem_stall),
    .iStall      (stall),
    .iRedirect   (redirect),
    .iRedirectPC (redirect_pc),
    .oIR         (ir),
    .oIR_opcode  (ir_opcode),
    .oIR_func    (ir_func),
    .oPC4        (pc4),
    .oValid      (valid),
    .oMisalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0001;
    if (a == 32'h4) return 32'h2009_0002;
    return 32'h3C00_0000 ^ a;
  endfunction

  assign mem_rdata = word_at(mem_addr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_stall   = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #12;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("dead_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("f0_req", {31'd0, mem_req}, 32'd1);
    chk("f0_addr", mem_addr, 32'h0);
    tick();
    chk("i0_ir", ir, 32'h2008_0001);
    chk("i0_pc4", pc4, 32'h4);
    chk("i0_valid", {31'd0, valid}, 32'd1);
    chk("i0_op", {26'd0, ir_opcode}, 32'h08);
    chk("f1_addr", mem_addr, 32'h4);
    tick();
    chk("i1_ir", ir, 32'h2009_0002);
    chk("i1_pc4", pc4, 32'h8);
    chk("i1_func", {26'd0, ir_func}, 32'h02);
    chk("f2_addr", mem_addr, 32'h8);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_addr", mem_addr, 32'h8);
      chk("ms_bubble", {31'd0, valid}, 32'd0);
      chk("ms_ir", ir, 32'h0);
    end
    mem_stall = 1'b0;
    tick();
    chk("i2_ir", ir, word_at(32'h8));
    chk("i2_pc4", pc4, 32'hC);
    chk("f3_addr", mem_addr, 32'hC);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("st_ir", ir, word_at(32'h8));
      chk("st_pc4", pc4, 32'hC);
      chk("st_req", {31'd0, mem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("sk_ir", ir, word_at(32'hC));
    chk("sk_pc4", pc4, 32'h10);
    chk("sk_valid", {31'd0, valid}, 32'd1);
    chk("f4_addr", mem_addr, 32'h10);
    mem_stall   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("rd_mis", {31'd0, misalign}, 32'd0);
    tick();
    redirect = 1'b0;
    chk("dr_addr", mem_addr, 32'h10);
    chk("dr_req", {31'd0, mem_req}, 32'd1);
    chk("dr_valid", {31'd0, valid}, 32'd0);
    tick();
    chk("dr_addr2", mem_addr, 32'h10);
    mem_stall = 1'b0;
    tick();
    chk("dr_disc", {31'd0, valid}, 32'd0);
    chk("rd_addr", mem_addr, 32'h40);
    tick();
    chk("rd_pc4", pc4, 32'h44);
    chk("rd_ir", ir, word_at(32'h40));
    chk("rd_valid", {31'd0, valid}, 32'd1);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h43;
    #1;
    chk("ma_pulse", {31'd0, misalign}, 32'd1);
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    #1;
    chk("ma_clear", {31'd0, misalign}, 32'd0);
    chk("ma_bubble", {31'd0, valid}, 32'd0);
    chk("ma_ir", ir, 32'h0);
    chk("ma_addr", mem_addr, 32'h40);
    tick();
    chk("ma_pc4", pc4, 32'h44);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wr_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc4", pc4, 32'h0);
    chk("wr_ir", ir, word_at(32'hFFFF_FFFC));
    chk("wr_next", mem_addr, 32'h0);
    mem_stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req", {31'd0, mem_req}, 32'd0);
    chk("ar_valid", {31'd0, valid}, 32'd0);
    chk("ar_addr", mem_addr, 32'h0);
    #20;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
